ntt_inverse_core: RTL and testbench

NTT_INVERSE_CORE -- requirements
Module: ntt_inverse_core

---
 rtl/ntt_pkg.sv | 59 +++++
 rtl/ntt_inv_twiddle_rom_x256.sv | 34 +++
 rtl/ntt_inverse_core.sv | 169 ++++++++++++++++
 tb/tb_ntt_inverse_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants, FSM state type and branchless mod-q arithmetic.
package ntt_pkg;

  localparam int N          = 256;
  localparam int LOGN       = 8;
  localparam int Q          = 3329;
  localparam int QINV       = 62209;
  localparam int N_INV_MONT = 256;

  // 17 is a primitive 256th root of unity mod q; 1175 is its inverse.
  localparam int ZETA_INV   = 1175;
  // 2^16 mod q, used to move twiddles into the Montgomery domain.
  localparam int R_MOD_Q    = 2285;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SCALE,
    S_DONE
  } ntt_state_t;

  typedef logic [15:0] coeff_t;

  localparam coeff_t Q16    = 16'(Q);
  localparam coeff_t QINV16 = 16'(QINV);

  // (a + b) mod q for a, b in [0,q): subtract q, add it back if negative.
  function automatic coeff_t add_mod_q(input coeff_t a, input coeff_t b);
    coeff_t s;
    s = a + b - Q16;
    return s + (Q16 & {16{s[15]}});
  endfunction

  // (a - b) mod q for a, b in [0,q).
  function automatic coeff_t sub_mod_q(input coeff_t a, input coeff_t b);
    coeff_t d;
    d = a - b;
    return d + (Q16 & {16{d[15]}});
  endfunction

  // x * w * 2^-16 mod q. t - u*q is an exact multiple of 2^16, so the
  // upper half is the signed result in (-q, q) before correction.
  function automatic coeff_t montgomery_mul(input coeff_t x, input coeff_t w);
    logic [31:0] t;
    logic [31:0] uq;
    coeff_t      u;
    coeff_t      r;
    coeff_t      r1;
    coeff_t      r2;
    t  = {16'd0, x} * {16'd0, w};
    u  = t[15:0] * QINV16;
    uq = {16'd0, u} * 32'(Q);
    r  = 16'((t - uq) >> 16);
    r1 = r + (Q16 & {16{r[15]}});
    r2 = r1 - Q16;
    return r2 + (Q16 & {16{r2[15]}});
  endfunction

endpackage

// File: rtl/ntt_inv_twiddle_rom_x256.sv
// Dual-read combinational ROM of inverse twiddles zeta^-i * 2^16 mod q.
module ntt_inv_twiddle_rom_x256
  import ntt_pkg::*;
(
  input  logic [7:0]  addr_a,
  input  logic [7:0]  addr_b,
  output logic [15:0] dout_a,
  output logic [15:0] dout_b
);

  // Square-and-multiply so each entry folds at elaboration in a few steps.
  function automatic logic [15:0] tw_value(input int idx);
    int acc;
    int base;
    acc  = R_MOD_Q;
    base = ZETA_INV;
    for (int bitn = 0; bitn < 8; bitn++) begin
      if (idx[bitn]) acc = (acc * base) % Q;
      base = (base * base) % Q;
    end
    return 16'(acc);
  endfunction

  logic [15:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [15:0] TW = tw_value(i);
    assign rom[i] = TW;
  end

  assign dout_a = rom[addr_a];
  assign dout_b = rom[addr_b];

endmodule

// File: rtl/ntt_inverse_core.sv
// In-place 256-point inverse NTT: Gentleman-Sande stages 7..0, then 1/N scale.
module ntt_inverse_core
  import ntt_pkg::*;
#(
  parameter int W          = 16,
  parameter int N          = 256,
  parameter int LOGN       = 8,
  parameter int Q          = 3329,
  parameter int QINV       = 62209,
  parameter int N_INV_MONT = 256
) (
  input  logic         clk_core,
  input  logic         rst_n,
  input  logic         start,
  input  logic         z_wr_en,
  input  logic [7:0]   z_wr_addr,
  input  logic [W-1:0] z_wr_data,
  input  logic         rd_en,
  input  logic [7:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] STAGE_TOP = 3'(LOGN - 1);
  localparam logic [8:0] N9        = 9'(N);

  logic [W-1:0] lanes [N];

  ntt_state_t state_q, state_d;
  logic [2:0] stage_q;
  logic [6:0] idx_q;
  logic       busy_d, done_d;

  logic [7:0]   k0, k1, lane_mask, half;
  logic [7:0]   a0, b0, a1, b1;
  logic [8:0]   tw_idx0, tw_idx1;
  logic [W-1:0] tw0, tw1;
  logic [W-1:0] a0_new, b0_new, a1_new, b1_new;
  logic [7:0]   sc_addr0, sc_addr1;
  logic [W-1:0] sc0, sc1;

  ntt_inv_twiddle_rom_x256 u_rom (
    .addr_a (tw_idx0[7:0]),
    .addr_b (tw_idx1[7:0]),
    .dout_a (tw0),
    .dout_b (tw1)
  );

  // Next-state logic; busy follows the state being entered, done marks leaving S_DONE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == 7'd126 && stage_q == 3'd0) state_d = S_SCALE;
      S_SCALE: if (idx_q == 7'd127) state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, stage and butterfly/scale index registers plus registered status.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= STAGE_TOP;
      idx_q   <= 7'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
      case (state_q)
        S_IDLE: if (start) begin
          stage_q <= STAGE_TOP;
          idx_q   <= 7'd0;
        end
        S_RUN: begin
          if (idx_q == 7'd126) begin
            idx_q <= 7'd0;
            if (stage_q != 3'd0) stage_q <= stage_q - 3'd1;
          end else begin
            idx_q <= idx_q + 7'd2;
          end
        end
        S_SCALE: idx_q <= idx_q + 7'd1;
        default: begin
          stage_q <= STAGE_TOP;
          idx_q   <= 7'd0;
        end
      endcase
    end
  end

  // Butterfly lane pairs and twiddle indices for k and k+1, plus scale results.
  always_comb begin
    k0        = {1'b0, idx_q};
    k1        = k0 + 8'd1;
    half      = 8'd1 << stage_q;
    lane_mask = half - 8'd1;
    a0 = ((k0 >> stage_q) << ({1'b0, stage_q} + 4'd1)) | (k0 & lane_mask);
    a1 = ((k1 >> stage_q) << ({1'b0, stage_q} + 4'd1)) | (k1 & lane_mask);
    b0 = a0 + half;
    b1 = a1 + half;
    tw_idx0 = {1'b0, k0 & lane_mask} << (3'd7 - stage_q);
    tw_idx1 = {1'b0, k1 & lane_mask} << (3'd7 - stage_q);
    a0_new = add_mod_q(lanes[a0], lanes[b0]);
    b0_new = montgomery_mul(sub_mod_q(lanes[a0], lanes[b0]), tw0);
    a1_new = add_mod_q(lanes[a1], lanes[b1]);
    b1_new = montgomery_mul(sub_mod_q(lanes[a1], lanes[b1]), tw1);
    sc_addr0 = {idx_q, 1'b0};
    sc_addr1 = {idx_q, 1'b1};
    sc0 = montgomery_mul(lanes[sc_addr0], 16'(N_INV_MONT));
    sc1 = montgomery_mul(lanes[sc_addr1], 16'(N_INV_MONT));
  end

  // Lane storage: host writes only while idle, butterflies in S_RUN, scaling in S_SCALE.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) lanes[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (z_wr_en) lanes[z_wr_addr] <= z_wr_data;
        S_RUN: begin
          lanes[a0] <= a0_new;
          lanes[b0] <= b0_new;
          lanes[a1] <= a1_new;
          lanes[b1] <= b1_new;
        end
        S_SCALE: begin
          lanes[sc_addr0] <= sc0;
          lanes[sc_addr1] <= sc1;
        end
        default: ;
      endcase
    end
  end

  // Registered read port; sees lane contents from before this cycle's update.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= lanes[rd_addr];
    end
  end

  // Twiddle addresses must stay inside the ROM and the module parameters must
  // agree with the constants baked into the shared arithmetic.
  always_ff @(posedge clk_core) begin
    if (rst_n) begin
      assert (Q == ntt_pkg::Q && QINV == ntt_pkg::QINV);
      if (state_q == S_RUN) begin
        assert (tw_idx0 < N9 && tw_idx1 < N9);
        assert (a0_new < 16'(Q) && b0_new < 16'(Q) && a1_new < 16'(Q) && b1_new < 16'(Q));
      end
    end
  end

endmodule

// File: tb/tb_ntt_inverse_core.sv
// Directed bench for ntt_inverse_core: timing, scaling, twiddles, reset abort, read port.
module tb_ntt_inverse_core;

  localparam int Q = 3329;

  logic        clk_core;
  logic        rst_n;
  logic        start;
  logic        z_wr_en;
  logic [7:0]  z_wr_addr;
  logic [15:0] z_wr_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  int stim        [256];
  int expectLanes [256];

  ntt_inverse_core dut (
    .clk_core  (clk_core),
    .rst_n     (rst_n),
    .start     (start),
    .z_wr_en   (z_wr_en),
    .z_wr_addr (z_wr_addr),
    .z_wr_data (z_wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Writes stim[] into all 256 lanes through the host write port.
  task automatic applyStimulus();
    for (int i = 0; i < 256; i++) begin
      z_wr_en   = 1'b1;
      z_wr_addr = 8'(i);
      z_wr_data = 16'(stim[i]);
      tick();
    end
    z_wr_en = 1'b0;
  endtask

  task automatic readLane(input int addr, output int val);
    rd_en   = 1'b1;
    rd_addr = 8'(addr);
    tick();
    rd_en = 1'b0;
    val   = int'(rd_data);
  endtask

  task automatic checkAllLanes(input string tag);
    int v;
    for (int i = 0; i < 256; i++) begin
      readLane(i, v);
      checkOutput($sformatf("%s_lane%0d", tag, i), v, expectLanes[i]);
    end
  endtask

  // Starts a transform, optionally injecting start+write(5,99) at run cycle injectAt.
  task automatic runTransform(input string tag, input int injectAt);
    int lat;
    int busyCycles;
    bit seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat        = 0;
    busyCycles = busy ? 1 : 0;
    seen       = 1'b0;
    while (!seen && lat < 2000) begin
      if (lat == injectAt) begin
        start     = 1'b1;
        z_wr_en   = 1'b1;
        z_wr_addr = 8'd5;
        z_wr_data = 16'd99;
      end
      tick();
      lat++;
      start   = 1'b0;
      z_wr_en = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) busyCycles++;
    end
    checkOutput({tag, "_latency"}, lat, 641);
    checkOutput({tag, "_busy_cycles"}, busyCycles, 641);
    checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
    tick();
    checkOutput({tag, "_done_width"}, int'(done), 0);
  endtask

  task automatic fillConst(input int v);
    for (int i = 0; i < 256; i++) stim[i] = v;
  endtask

  task automatic expectDelta(input int v0);
    for (int i = 0; i < 256; i++) expectLanes[i] = 0;
    expectLanes[0] = v0;
  endtask

  function automatic int bitrev8(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 8; b++) if (x[b]) r = r | (1 << (7 - b));
    return r;
  endfunction

  int rv;
  int doneSeen;
  int pw [256];
  int xr [256];
  int xs [256];

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    z_wr_en   = 1'b0;
    z_wr_addr = 8'd0;
    z_wr_data = 16'd0;
    rd_en     = 1'b0;
    rd_addr   = 8'd0;

    // Reset state
    #2;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rd_valid", int'(rd_valid), 0);
    checkOutput("reset_rd_data", int'(rd_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    readLane(7, rv);
    checkOutput("reset_lane7", rv, 0);

    // Constant 17 -> 17 at lane 0, zero elsewhere
    $display("[TB] constant input");
    fillConst(17);
    applyStimulus();
    runTransform("const", -1);
    expectDelta(17);
    checkAllLanes("const");

    // Read port in idle, then no read -> rd_valid drops
    rd_en   = 1'b1;
    rd_addr = 8'd0;
    tick();
    rd_en = 1'b0;
    checkOutput("rdport_valid", int'(rd_valid), 1);
    checkOutput("rdport_data", int'(rd_data), 17);
    tick();
    checkOutput("rdport_valid_idle", int'(rd_valid), 0);

    // Zero input
    $display("[TB] zero input");
    fillConst(0);
    applyStimulus();
    runTransform("zero", -1);
    expectDelta(0);
    checkAllLanes("zero");

    // Impulse at lane 0 spreads to all lanes, each scaled by 256^-1 = 3316
    $display("[TB] impulse input");
    fillConst(0);
    stim[0] = 1;
    applyStimulus();
    runTransform("impulse", -1);
    for (int i = 0; i < 256; i++) expectLanes[i] = 3316;
    checkAllLanes("impulse");

    // start and lane write during the run are ignored
    $display("[TB] ignored start/write");
    fillConst(17);
    applyStimulus();
    runTransform("ignored", 100);
    expectDelta(17);
    checkAllLanes("ignored");

    // Reset in the middle of a run aborts with no done pulse
    $display("[TB] reset abort");
    fillConst(17);
    applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_rd_valid", int'(rd_valid), 0);
    tick();
    rst_n = 1'b1;
    doneSeen = 0;
    for (int c = 0; c < 700; c++) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_busy_after", int'(busy), 0);
    expectDelta(0);
    checkAllLanes("abort");
    fillConst(17);
    applyStimulus();
    runTransform("rerun", -1);
    expectDelta(17);
    checkAllLanes("rerun");

    // Round trip: forward transform modelled in the bench with root 17
    $display("[TB] round trip");
    pw[0] = 1;
    for (int e = 1; e < 256; e++) pw[e] = (pw[e-1] * 17) % Q;
    for (int i = 0; i < 256; i++) xr[i] = int'($urandom_range(0, Q - 1));
    for (int m = 0; m < 256; m++) xs[m] = xr[bitrev8(m)];
    for (int k = 0; k < 256; k++) begin
      int acc;
      acc = 0;
      for (int n = 0; n < 256; n++) acc = (acc + xs[n] * pw[(n * k) % 256]) % Q;
      stim[k] = acc;
    end
    applyStimulus();
    runTransform("roundtrip", -1);
    for (int i = 0; i < 256; i++) expectLanes[i] = xr[i];
    checkAllLanes("roundtrip");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
